ac_stream_matcher: RTL and testbench

//  Parametrised Aho-Corasick match engine with a runtime-loadable full-DFA transition table (failure links pre-folded).

---
 rtl/ac_stream_matcher.sv | 100 ++++++++++
 tb/tb_ac_stream_matcher.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_stream_matcher.sv
// Aho-Corasick stream matcher: one symbol per cycle through a runtime-loaded full DFA table,
// reporting the bitmap of patterns ending at each accepted stream position.
module ac_stream_matcher #(
  parameter int SYM_W   = 8,
  parameter int NSTATES = 32,
  parameter int STATE_W = $clog2(NSTATES),
  parameter int NPAT    = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               initialize,
  input  logic               cfg_mode,
  input  logic               cfg_we,
  input  logic               cfg_sel,
  input  logic [STATE_W-1:0] cfg_state,
  input  logic [SYM_W-1:0]   cfg_sym,
  input  logic [STATE_W-1:0] cfg_next,
  input  logic [NPAT-1:0]    cfg_out,
  input  logic               en,
  input  logic [SYM_W-1:0]   symbol,
  output logic               rdy,
  output logic               match,
  output logic [NPAT-1:0]    match_id,
  output logic [CNT_W-1:0]   match_pos,
  output logic [STATE_W-1:0] cur_state,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               ovf
);

  typedef enum logic {CONFIG, RUN} mode_t;

  mode_t              mode;
  logic [STATE_W-1:0] next_tab [NSTATES][2**SYM_W];
  logic [NPAT-1:0]    out_tab  [NSTATES];
  logic [CNT_W-1:0]   pos;
  logic [STATE_W-1:0] raw_next;
  logic [STATE_W-1:0] next_state;
  logic [NPAT-1:0]    next_out;
  logic               accept;
  logic               row_ok;

  assign rdy        = (mode == RUN) & ~cfg_mode & ~initialize;
  assign accept     = en & rdy;
  assign raw_next   = next_tab[cur_state][symbol];
  // Table entries pointing past the last state fall back to the root
  assign next_state = (int'(raw_next) < NSTATES) ? raw_next : '0;
  assign next_out   = out_tab[next_state];
  assign row_ok     = int'(cfg_state) < NSTATES;

  // Tables carry no reset so a loaded pattern set survives RST
  always_ff @(posedge clk) begin
    if (mode == CONFIG && cfg_we && row_ok) begin
      if (cfg_sel)
        out_tab[cfg_state] <= cfg_out;
      else
        next_tab[cfg_state][cfg_sym] <= cfg_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode      <= CONFIG;
      cur_state <= '0;
      pos       <= '0;
      match     <= 1'b0;
      match_id  <= '0;
      match_pos <= '0;
      match_cnt <= '0;
      ovf       <= 1'b0;
    end else begin
      mode <= cfg_mode ? CONFIG : RUN;
      if (initialize) begin
        cur_state <= '0;
        pos       <= '0;
        match     <= 1'b0;
        match_id  <= '0;
        match_pos <= '0;
        match_cnt <= '0;
        ovf       <= 1'b0;
      end else if (accept) begin
        cur_state <= next_state;
        match_id  <= next_out;
        match     <= |next_out;
        match_pos <= pos;
        pos       <= pos + CNT_W'(1);
        // Count match cycles, not patterns; saturate and flag instead of wrapping
        if (|next_out) begin
          if (match_cnt == {CNT_W{1'b1}})
            ovf <= 1'b1;
          else
            match_cnt <= match_cnt + CNT_W'(1);
        end
      end else begin
        match <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ac_stream_matcher.sv
// Bench for ac_stream_matcher: two instances (default and a small 20-state, 4-bit-counter one)
// share stimulus and are checked every cycle against a table-driven behavioural model.
module tb_ac_stream_matcher;

  localparam logic [7:0] SYM_A = 8'h61;
  localparam logic [7:0] SYM_B = 8'h62;
  localparam logic [7:0] SYM_X = 8'h78;

  logic       clk;
  logic       rst;
  logic       initialize;
  logic       cfg_mode;
  logic       cfg_we;
  logic       cfg_sel;
  logic [4:0] cfg_state;
  logic [7:0] cfg_sym;
  logic [4:0] cfg_next;
  logic [7:0] cfg_out;
  logic       en;
  logic [7:0] symbol;

  logic        d0_rdy, d0_match, d0_ovf;
  logic [7:0]  d0_match_id;
  logic [15:0] d0_match_pos, d0_match_cnt;
  logic [4:0]  d0_cur_state;
  logic        d1_rdy, d1_match, d1_ovf;
  logic [7:0]  d1_match_id;
  logic [3:0]  d1_match_pos, d1_match_cnt;
  logic [4:0]  d1_cur_state;

  int n_cmp  = 0;
  int n_fail = 0;

  int ns   [2] = '{32, 20};
  int cmax [2] = '{65535, 15};
  int m_next [2][32][256];
  int m_out  [2][32];
  bit m_run  [2];
  bit m_match[2];
  bit m_ovf  [2];
  int m_state[2];
  int m_pos  [2];
  int m_id   [2];
  int m_mpos [2];
  int m_cnt  [2];

  ac_stream_matcher u_dut (
    .clk(clk), .rst(rst), .initialize(initialize), .cfg_mode(cfg_mode),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_state(cfg_state), .cfg_sym(cfg_sym),
    .cfg_next(cfg_next), .cfg_out(cfg_out), .en(en), .symbol(symbol),
    .rdy(d0_rdy), .match(d0_match), .match_id(d0_match_id), .match_pos(d0_match_pos),
    .cur_state(d0_cur_state), .match_cnt(d0_match_cnt), .ovf(d0_ovf)
  );

  ac_stream_matcher #(.NSTATES(20), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .initialize(initialize), .cfg_mode(cfg_mode),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_state(cfg_state), .cfg_sym(cfg_sym),
    .cfg_next(cfg_next), .cfg_out(cfg_out), .en(en), .symbol(symbol),
    .rdy(d1_rdy), .match(d1_match), .match_id(d1_match_id), .match_pos(d1_match_pos),
    .cur_state(d1_cur_state), .match_cnt(d1_match_cnt), .ovf(d1_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one table lookup per accepted symbol, straight from the matcher rules
  task automatic model_reset(input int d);
    m_run[d] = 0; m_match[d] = 0; m_ovf[d] = 0;
    m_state[d] = 0; m_pos[d] = 0; m_id[d] = 0; m_mpos[d] = 0; m_cnt[d] = 0;
  endtask

  task automatic model_step(input int d);
    bit rdy_now;
    int s;
    rdy_now = m_run[d] && !cfg_mode && !initialize;
    if (!m_run[d] && cfg_we && int'(cfg_state) < ns[d]) begin
      if (cfg_sel) m_out[d][cfg_state] = int'(cfg_out);
      else         m_next[d][cfg_state][cfg_sym] = int'(cfg_next);
    end
    if (initialize) begin
      m_state[d] = 0; m_pos[d] = 0; m_match[d] = 0; m_id[d] = 0;
      m_mpos[d] = 0; m_cnt[d] = 0; m_ovf[d] = 0;
    end else if (en && rdy_now) begin
      s = m_next[d][m_state[d]][symbol];
      if (s >= ns[d]) s = 0;
      m_state[d] = s;
      m_id[d]    = m_out[d][s];
      m_match[d] = (m_id[d] != 0);
      m_mpos[d]  = m_pos[d];
      m_pos[d]   = (m_pos[d] + 1) % (cmax[d] + 1);
      if (m_match[d]) begin
        if (m_cnt[d] == cmax[d]) m_ovf[d] = 1;
        else m_cnt[d]++;
      end
    end else begin
      m_match[d] = 0;
    end
    m_run[d] = !cfg_mode;
  endtask

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) model_reset(d);
      else model_step(d);
    end
  end

  task automatic check_dut(input int d, input logic [31:0] a_rdy, input logic [31:0] a_match,
                           input logic [31:0] a_id, input logic [31:0] a_mpos,
                           input logic [31:0] a_state, input logic [31:0] a_cnt,
                           input logic [31:0] a_ovf);
    check_output($sformatf("d%0d_rdy", d), a_rdy, 32'(m_run[d] && !cfg_mode && !initialize));
    check_output($sformatf("d%0d_match", d), a_match, 32'(m_match[d]));
    check_output($sformatf("d%0d_match_id", d), a_id, m_id[d]);
    check_output($sformatf("d%0d_match_pos", d), a_mpos, m_mpos[d]);
    check_output($sformatf("d%0d_cur_state", d), a_state, m_state[d]);
    check_output($sformatf("d%0d_match_cnt", d), a_cnt, m_cnt[d]);
    check_output($sformatf("d%0d_ovf", d), a_ovf, 32'(m_ovf[d]));
  endtask

  always @(negedge clk) begin
    check_dut(0, 32'(d0_rdy), 32'(d0_match), 32'(d0_match_id), 32'(d0_match_pos),
              32'(d0_cur_state), 32'(d0_match_cnt), 32'(d0_ovf));
    check_dut(1, 32'(d1_rdy), 32'(d1_match), 32'(d1_match_id), 32'(d1_match_pos),
              32'(d1_cur_state), 32'(d1_match_cnt), 32'(d1_ovf));
  end

  // Inputs change 2 time units after the rising edge; outputs are read there too
  task automatic apply_stimulus(input logic init, input logic mode, input logic valid,
                                input logic [7:0] sym);
    initialize = init; cfg_mode = mode; en = valid; symbol = sym; cfg_we = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic cfg_write(input logic mode, input logic sel, input logic [4:0] st,
                           input logic [7:0] sym, input logic [4:0] nxt, input logic [7:0] outv);
    initialize = 1'b0; cfg_mode = mode; en = 1'b0;
    cfg_we = 1'b1; cfg_sel = sel; cfg_state = st; cfg_sym = sym; cfg_next = nxt; cfg_out = outv;
    @(posedge clk); #2;
    cfg_we = 1'b0;
  endtask

  function automatic logic [4:0] ac_next(input int s, input int c);
    if (s >= 4) return 5'($urandom_range(31));
    if (c == int'(SYM_A)) return 5'd1;
    if (c == int'(SYM_B)) return (s == 1) ? 5'd2 : 5'd3;
    return 5'd0;
  endfunction

  function automatic logic [7:0] ac_out(input int s);
    if (s == 2) return 8'h03;
    if (s == 3) return 8'h02;
    if (s < 4)  return 8'h00;
    return 8'($urandom_range(255));
  endfunction

  function automatic logic [7:0] pick_sym();
    case ($urandom_range(3))
      0: return SYM_A;
      1: return SYM_B;
      2: return SYM_X;
      default: return 8'($urandom_range(255));
    endcase
  endfunction

  logic mode_r;

  initial begin
    rst = 1'b1; initialize = 1'b0; cfg_mode = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0;
    cfg_state = '0; cfg_sym = '0; cfg_next = '0; cfg_out = '0; en = 1'b0; symbol = '0;
    repeat (2) @(posedge clk);
    #2;
    check_output("rst_state", 32'(d0_cur_state), 0);
    check_output("rst_rdy", 32'(d0_rdy), 0);
    check_output("rst_cnt", 32'(d0_match_cnt), 0);
    rst = 1'b0;

    for (int s = 0; s < 32; s++)
      for (int c = 0; c < 256; c++)
        cfg_write(1'b1, 1'b0, 5'(s), 8'(c), ac_next(s, c), 8'h00);
    for (int s = 0; s < 32; s++)
      cfg_write(1'b1, 1'b1, 5'(s), 8'h00, 5'd0, ac_out(s));

    // a,a,b: only the final b ends "ab" and "b"
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 1'b1, SYM_A);
    check_output("t1_match_a", 32'(d0_match), 0);
    apply_stimulus(1'b0, 1'b0, 1'b1, SYM_A);
    apply_stimulus(1'b0, 1'b0, 1'b1, SYM_B);
    check_output("t1_id", 32'(d0_match_id), 32'h03);
    check_output("t1_pos", 32'(d0_match_pos), 2);
    check_output("t1_state", 32'(d0_cur_state), 2);
    check_output("t1_cnt", 32'(d0_match_cnt), 1);

    // b,x,b with idle cycles between symbols
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 1'b1, SYM_B);
    check_output("t2_id0", 32'(d0_match_id), 32'h02);
    check_output("t2_pos0", 32'(d0_match_pos), 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, SYM_B);
    check_output("t2_gap", 32'(d0_match), 0);
    apply_stimulus(1'b0, 1'b0, 1'b1, SYM_X);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 1'b1, SYM_B);
    check_output("t2_pos2", 32'(d0_match_pos), 2);
    check_output("t2_cnt", 32'(d0_match_cnt), 2);

    // initialize drops the symbol presented with it
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 1'b1, SYM_A);
    apply_stimulus(1'b1, 1'b0, 1'b1, SYM_B);
    check_output("t3_state", 32'(d0_cur_state), 0);
    apply_stimulus(1'b0, 1'b0, 1'b1, SYM_B);
    check_output("t3_pos", 32'(d0_match_pos), 0);
    check_output("t3_id", 32'(d0_match_id), 32'h02);

    // config mode blocks symbols, run-mode writes are ignored, out-of-range next goes to root
    apply_stimulus(1'b0, 1'b1, 1'b1, SYM_A);
    check_output("t4_hold", 32'(d0_cur_state), 3);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    cfg_write(1'b0, 1'b1, 5'd3, 8'h00, 5'd0, 8'hff);
    apply_stimulus(1'b0, 1'b0, 1'b1, SYM_B);
    check_output("t4_ignored", 32'(d0_match_id), 32'h02);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
    cfg_write(1'b1, 1'b0, 5'd3, SYM_X, 5'd25, 8'h00);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    check_output("t4_resume", 32'(d0_cur_state), 3);
    apply_stimulus(1'b0, 1'b0, 1'b1, SYM_X);
    check_output("t4_big25", 32'(d0_cur_state), 25);
    check_output("t4_small0", 32'(d1_cur_state), 0);

    // 20 b's: small counters wrap position and saturate the match count
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (20) apply_stimulus(1'b0, 1'b0, 1'b1, SYM_B);
    check_output("t5_small_pos", 32'(d1_match_pos), 3);
    check_output("t5_big_pos", 32'(d0_match_pos), 19);
    check_output("t5_small_cnt", 32'(d1_match_cnt), 15);
    check_output("t5_small_ovf", 32'(d1_ovf), 1);
    check_output("t5_big_cnt", 32'(d0_match_cnt), 20);
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
    check_output("t5_clr_ovf", 32'(d1_ovf), 0);

    // asynchronous reset mid-stream keeps the tables
    apply_stimulus(1'b0, 1'b0, 1'b1, SYM_A);
    rst = 1'b1;
    #1;
    check_output("t6_async", 32'(d0_cur_state), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    check_output("t6_rdy", 32'(d0_rdy), 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 1'b1, SYM_A);
    apply_stimulus(1'b0, 1'b0, 1'b1, SYM_B);
    check_output("t6_id", 32'(d0_match_id), 32'h03);
    check_output("t6_pos", 32'(d0_match_pos), 1);

    // Random traffic, mode switches, table rewrites, initialize and reset pulses
    mode_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(999) < 3) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
      if (mode_r) mode_r = ($urandom_range(9) != 0);
      else        mode_r = ($urandom_range(99) == 0);
      initialize = ($urandom_range(63) == 0);
      cfg_mode   = mode_r;
      cfg_we     = ($urandom_range(3) == 0);
      cfg_sel    = 1'($urandom_range(1));
      cfg_state  = 5'($urandom_range(31));
      cfg_sym    = pick_sym();
      cfg_next   = 5'($urandom_range(31));
      cfg_out    = 8'($urandom_range(255));
      en         = ($urandom_range(3) != 0);
      symbol     = pick_sym();
      @(posedge clk); #2;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
